// File: rtl/fpu_cmp_class_pipe.sv
// fpu_cmp_class_pipe: two-stage pipelined sign-inject / min-max / compare /
// classify unit for an IEEE-754-style format of EXP_W exponent and FRAC_W
// fraction bits. Stage 1 registers the operands with their classification,
// stage 2 forms the result. Valid/ready on both sides; sticky NV for FCSR.
module fpu_cmp_class_pipe #(
  parameter int EXP_W   = 5,
  parameter int FRAC_W  = 10,
  parameter int FLOAT_W = 1 + EXP_W + FRAC_W
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         funct,
  input  logic [2:0]         rm,
  input  logic [FLOAT_W-1:0] rs1,
  input  logic [FLOAT_W-1:0] rs2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FLOAT_W-1:0] result,
  output logic               out_nv,
  output logic               out_illegal,
  output logic               nv_sticky,
  input  logic               nv_clear
);

  localparam int CLASSIFY_W = 10;

  // fpu_funct_t encodings used by the decode stage (RISC-V funct5 values)
  localparam logic [4:0] FUNCT_FSGNJ   = 5'b00100;
  localparam logic [4:0] FUNCT_FMINMAX = 5'b00101;
  localparam logic [4:0] FUNCT_FCOMP   = 5'b10100;
  localparam logic [4:0] FUNCT_FCLASS  = 5'b11100;

  // Canonical quiet NaN: positive, all-ones exponent, only the fraction MSB set
  localparam logic [FLOAT_W-1:0] CANON_NAN =
    FLOAT_W'({{EXP_W{1'b1}}, 1'b1}) << (FRAC_W - 1);

  generate
    if (FLOAT_W < CLASSIFY_W) begin : g_width_check
      $error("fpu_cmp_class_pipe: FLOAT_W must be at least CLASSIFY_W (10)");
    end
    if (FLOAT_W != 1 + EXP_W + FRAC_W) begin : g_format_check
      $error("fpu_cmp_class_pipe: FLOAT_W must equal 1+EXP_W+FRAC_W");
    end
  endgenerate

  typedef struct packed {
    logic sign;
    logic exp_zero;
    logic exp_ones;
    logic frac_zero;
    logic snan;
    logic qnan;
  } cls_t;

  function automatic cls_t classify(input logic [FLOAT_W-1:0] v);
    cls_t c;
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    e           = v[FRAC_W +: EXP_W];
    f           = v[FRAC_W-1:0];
    c.sign      = v[FLOAT_W-1];
    c.exp_zero  = (e == '0);
    c.exp_ones  = &e;
    c.frac_zero = (f == '0);
    c.snan      = c.exp_ones && !c.frac_zero && !f[FRAC_W-1];
    c.qnan      = c.exp_ones && f[FRAC_W-1];
    return c;
  endfunction

  // ---------------------------------------------------------------- handshake
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_adv;

  assign s2_adv    = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_adv;
  assign out_valid = s2_valid_q;

  // ------------------------------------------------------------------ stage 1
  logic [FLOAT_W-1:0] op_in [2];
  cls_t               cls_in [2];

  assign op_in[0] = rs1;
  assign op_in[1] = rs2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_classify
      assign cls_in[gi] = classify(op_in[gi]);
    end
  endgenerate

  logic [FLOAT_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [4:0]         s1_funct_q, s1_funct_d;
  logic [2:0]         s1_rm_q, s1_rm_d;
  cls_t               s1_ca_q, s1_ca_d, s1_cb_q, s1_cb_d;

  // Stage 1 loads a new request whenever it can hand its content onward
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_funct_d = s1_funct_q;
    s1_rm_d    = s1_rm_q;
    s1_ca_d    = s1_ca_q;
    s1_cb_d    = s1_cb_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d     = rs1;
        s1_b_d     = rs2;
        s1_funct_d = funct;
        s1_rm_d    = rm;
        s1_ca_d    = cls_in[0];
        s1_cb_d    = cls_in[1];
      end
    end
  end

  // Stage 1 registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_funct_q <= '0;
      s1_rm_q    <= '0;
      s1_ca_q    <= '0;
      s1_cb_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_funct_q <= s1_funct_d;
      s1_rm_q    <= s1_rm_d;
      s1_ca_q    <= s1_ca_d;
      s1_cb_q    <= s1_cb_d;
    end
  end

  // ------------------------------------------------------- stage 2 datapath
  logic [FLOAT_W-2:0]    mag_a, mag_b;
  logic                  mag_lt, mag_eq, both_zero, any_nan, any_snan;
  logic                  lt_total, lt_ieee, eq_ieee, a_nan, b_nan;
  logic [CLASSIFY_W-1:0] cls_vec;
  logic [FLOAT_W-1:0]    res_c;
  logic                  nv_c, ill_c;
  logic                  unused_cls_bits;

  assign unused_cls_bits = s1_cb_q.exp_ones;

  // Magnitude/sign relations and the one-hot class of rs1
  always_comb begin
    mag_a     = s1_a_q[FLOAT_W-2:0];
    mag_b     = s1_b_q[FLOAT_W-2:0];
    mag_lt    = (mag_a < mag_b);
    mag_eq    = (mag_a == mag_b);
    a_nan     = s1_ca_q.snan || s1_ca_q.qnan;
    b_nan     = s1_cb_q.snan || s1_cb_q.qnan;
    any_nan   = a_nan || b_nan;
    any_snan  = s1_ca_q.snan || s1_cb_q.snan;
    both_zero = s1_ca_q.exp_zero && s1_ca_q.frac_zero &&
                s1_cb_q.exp_zero && s1_cb_q.frac_zero;
    // Total order on non-NaN values where -0 sorts below +0 (used by min/max)
    if (s1_ca_q.sign != s1_cb_q.sign) begin
      lt_total = s1_ca_q.sign;
    end else if (!s1_ca_q.sign) begin
      lt_total = mag_lt;
    end else begin
      lt_total = !mag_lt && !mag_eq;
    end
    // IEEE comparisons treat -0 and +0 as equal
    lt_ieee = lt_total && !both_zero;
    eq_ieee = (s1_a_q == s1_b_q) || both_zero;

    cls_vec    = '0;
    cls_vec[0] = s1_ca_q.sign  && s1_ca_q.exp_ones && s1_ca_q.frac_zero;
    cls_vec[1] = s1_ca_q.sign  && !s1_ca_q.exp_zero && !s1_ca_q.exp_ones;
    cls_vec[2] = s1_ca_q.sign  && s1_ca_q.exp_zero && !s1_ca_q.frac_zero;
    cls_vec[3] = s1_ca_q.sign  && s1_ca_q.exp_zero && s1_ca_q.frac_zero;
    cls_vec[4] = !s1_ca_q.sign && s1_ca_q.exp_zero && s1_ca_q.frac_zero;
    cls_vec[5] = !s1_ca_q.sign && s1_ca_q.exp_zero && !s1_ca_q.frac_zero;
    cls_vec[6] = !s1_ca_q.sign && !s1_ca_q.exp_zero && !s1_ca_q.exp_ones;
    cls_vec[7] = !s1_ca_q.sign && s1_ca_q.exp_ones && s1_ca_q.frac_zero;
    cls_vec[8] = s1_ca_q.snan;
    cls_vec[9] = s1_ca_q.qnan;
  end

  // Result selection per funct/rm; anything unsupported yields a flagged zero
  always_comb begin
    res_c = '0;
    nv_c  = 1'b0;
    ill_c = 1'b0;
    unique case (s1_funct_q)
      FUNCT_FSGNJ: begin
        unique case (s1_rm_q)
          3'b000:  res_c = {s1_cb_q.sign, mag_a};
          3'b001:  res_c = {!s1_cb_q.sign, mag_a};
          3'b010:  res_c = {s1_ca_q.sign ^ s1_cb_q.sign, mag_a};
          default: ill_c = 1'b1;
        endcase
      end
      FUNCT_FMINMAX: begin
        if (s1_rm_q == 3'b000 || s1_rm_q == 3'b001) begin
          nv_c = any_snan;
          if (a_nan && b_nan) begin
            res_c = CANON_NAN;
          end else if (a_nan) begin
            res_c = s1_b_q;
          end else if (b_nan) begin
            res_c = s1_a_q;
          end else if (s1_rm_q == 3'b000) begin
            res_c = lt_total ? s1_a_q : s1_b_q;
          end else begin
            res_c = lt_total ? s1_b_q : s1_a_q;
          end
        end else begin
          ill_c = 1'b1;
        end
      end
      FUNCT_FCOMP: begin
        unique case (s1_rm_q)
          3'b010: begin
            res_c[0] = !any_nan && eq_ieee;
            nv_c     = any_snan;
          end
          3'b001: begin
            res_c[0] = !any_nan && lt_ieee;
            nv_c     = any_nan;
          end
          3'b000: begin
            res_c[0] = !any_nan && (lt_ieee || eq_ieee);
            nv_c     = any_nan;
          end
          default: ill_c = 1'b1;
        endcase
      end
      FUNCT_FCLASS: begin
        if (s1_rm_q == 3'b001) begin
          res_c[CLASSIFY_W-1:0] = cls_vec;
        end else begin
          ill_c = 1'b1;
        end
      end
      default: ill_c = 1'b1;
    endcase
  end

  // ------------------------------------------------------------------ stage 2
  logic [FLOAT_W-1:0] result_q, result_d;
  logic               out_nv_q, out_nv_d;
  logic               out_illegal_q, out_illegal_d;
  logic               nv_sticky_q, nv_sticky_d;

  // Output stage holds its contents while stalled; sticky NV set beats clear
  always_comb begin
    s2_valid_d    = s2_valid_q;
    result_d      = result_q;
    out_nv_d      = out_nv_q;
    out_illegal_d = out_illegal_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d      = res_c;
        out_nv_d      = nv_c;
        out_illegal_d = ill_c;
      end
    end
    nv_sticky_d = nv_sticky_q;
    if (s2_valid_q && out_ready && out_nv_q) begin
      nv_sticky_d = 1'b1;
    end else if (nv_clear) begin
      nv_sticky_d = 1'b0;
    end
  end

  // Stage 2 and sticky-flag registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s2_valid_q    <= 1'b0;
      result_q      <= '0;
      out_nv_q      <= 1'b0;
      out_illegal_q <= 1'b0;
      nv_sticky_q   <= 1'b0;
    end else begin
      s2_valid_q    <= s2_valid_d;
      result_q      <= result_d;
      out_nv_q      <= out_nv_d;
      out_illegal_q <= out_illegal_d;
      nv_sticky_q   <= nv_sticky_d;
    end
  end

  assign result      = result_q;
  assign out_nv      = out_nv_q;
  assign out_illegal = out_illegal_q;
  assign nv_sticky   = nv_sticky_q;

endmodule

// File: tb/tb_fpu_cmp_class_pipe.sv
// Scoreboard bench for fpu_cmp_class_pipe: a half-precision instance is
// driven through all op groups, backpressure and mid-flight reset, and a
// single-precision instance checks the parametrised format.
module tb_fpu_cmp_class_pipe;

  localparam logic [4:0] F_SGNJ   = 5'b00100;
  localparam logic [4:0] F_MINMAX = 5'b00101;
  localparam logic [4:0] F_COMP   = 5'b10100;
  localparam logic [4:0] F_CLASS  = 5'b11100;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  funct = '0;
  logic [2:0]  rm = '0;
  logic [15:0] rs1 = '0, rs2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        out_nv, out_illegal, nv_sticky;
  logic        nv_clear = 1'b0;

  logic        c_in_valid = 1'b0;
  logic        c_in_ready;
  logic [4:0]  c_funct = '0;
  logic [2:0]  c_rm = '0;
  logic [31:0] c_rs1 = '0, c_rs2 = '0;
  logic        c_out_valid;
  logic [31:0] c_result;
  logic        c_out_nv, c_out_illegal, c_nv_sticky;

  always #5 CLK = ~CLK;

  fpu_cmp_class_pipe u_dut (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .rm(rm), .rs1(rs1), .rs2(rs2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_nv(out_nv), .out_illegal(out_illegal),
    .nv_sticky(nv_sticky), .nv_clear(nv_clear)
  );

  fpu_cmp_class_pipe #(.EXP_W(8), .FRAC_W(23)) u_dut32 (
    .CLK(CLK), .nRST(nRST), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .funct(c_funct), .rm(c_rm), .rs1(c_rs1), .rs2(c_rs2),
    .out_valid(c_out_valid), .out_ready(1'b1), .result(c_result),
    .out_nv(c_out_nv), .out_illegal(c_out_illegal),
    .nv_sticky(c_nv_sticky), .nv_clear(1'b0)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [15:0] res;
    logic        nv;
    logic        ill;
    logic [31:0] acc;
  } exp_t;

  // Reference model: orders non-NaN values by a signed integer key
  function automatic exp_t model(input logic [4:0] f, input logic [2:0] r,
                                 input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic an, bn, as, bs, a_less;
    int   ka, kb, idx;
    e  = '0;
    an = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
    bn = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
    as = an && !a[9];
    bs = bn && !b[9];
    ka = int'(a[14:0]); if (a[15]) ka = -ka;
    kb = int'(b[14:0]); if (b[15]) kb = -kb;
    a_less = (ka < kb) || (ka == kb && a[15] && !b[15]);
    case (f)
      F_SGNJ: case (r)
        3'd0:    e.res = {b[15], a[14:0]};
        3'd1:    e.res = {~b[15], a[14:0]};
        3'd2:    e.res = {a[15] ^ b[15], a[14:0]};
        default: e.ill = 1'b1;
      endcase
      F_MINMAX: if (r > 3'd1) e.ill = 1'b1;
        else begin
          e.nv = as | bs;
          if (an && bn)  e.res = 16'h7E00;
          else if (an)   e.res = b;
          else if (bn)   e.res = a;
          else           e.res = ((r == 3'd0) == a_less) ? a : b;
        end
      F_COMP: case (r)
        3'd2: begin e.res[0] = !(an | bn) && (ka == kb); e.nv = as | bs; end
        3'd1: begin e.res[0] = !(an | bn) && (ka < kb);  e.nv = an | bn; end
        3'd0: begin e.res[0] = !(an | bn) && (ka <= kb); e.nv = an | bn; end
        default: e.ill = 1'b1;
      endcase
      F_CLASS: if (r != 3'd1) e.ill = 1'b1;
        else begin
          if (an)                        idx = as ? 8 : 9;
          else if (a[14:10] == 5'h1F)    idx = a[15] ? 0 : 7;
          else if (a[14:10] == 5'h00)    idx = (a[9:0] == 0) ? (a[15] ? 3 : 4) : (a[15] ? 2 : 5);
          else                           idx = a[15] ? 1 : 6;
          e.res = 16'(1) << idx;
        end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  exp_t        sb [$];
  int          cyc = 0;
  int          n_acc = 0;
  int          n_out = 0;
  bit          lat_check = 1'b1;
  logic        model_sticky = 1'b0;
  bit          hold_valid = 1'b0;
  logic [17:0] hold_val;

  always @(posedge CLK) cyc++;

  // Monitor: score handoffs, hold stability and sticky NV; log each result
  always @(negedge CLK) begin
    exp_t e;
    if (!nRST) begin
      sb.delete();
      model_sticky = 1'b0;
      hold_valid   = 1'b0;
    end else begin
      check("nv_sticky", nv_sticky, model_sticky);
      e = '0;
      if (out_valid && out_ready) begin
        n_out++;
        hold_valid = 1'b0;
        if (sb.size() == 0) begin
          check("spurious_output", 1, 0);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("out_nv", out_nv, e.nv);
          check("out_illegal", out_illegal, e.ill);
          if (lat_check) check("latency", cyc - e.acc, 2);
          $display("[cyc %0d] result=%h nv=%b illegal=%b", cyc, result, out_nv, out_illegal);
        end
      end else if (out_valid) begin
        if (hold_valid) check("hold_stable", {result, out_nv, out_illegal}, hold_val);
        hold_val   = {result, out_nv, out_illegal};
        hold_valid = 1'b1;
      end else begin
        hold_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        exp_t m;
        m     = model(funct, rm, rs1, rs2);
        m.acc = cyc;
        sb.push_back(m);
        n_acc++;
      end
      if (out_valid && out_ready && e.nv) model_sticky = 1'b1;
      else if (nv_clear)                  model_sticky = 1'b0;
    end
  end

  task automatic send(input logic [4:0] f, input logic [2:0] r,
                      input logic [15:0] a, input logic [15:0] b);
    bit acc;
    int t;
    in_valid = 1'b1; funct = f; rm = r; rs1 = a; rs2 = b;
    t = 0;
    do begin
      @(negedge CLK); acc = in_ready;
      @(posedge CLK); #1;
      t++;
    end while (!acc && t < 50);
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 100) begin
      @(posedge CLK); #1; t++;
    end
    if (t >= 100) check("drain_timeout", 0, 1);
  endtask

  task automatic send32(input string tag, input logic [4:0] f, input logic [2:0] r,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_nv);
    int t;
    c_in_valid = 1'b1; c_funct = f; c_rm = r; c_rs1 = a; c_rs2 = b;
    t = 0;
    @(negedge CLK);
    while (!c_in_ready && t < 20) begin @(negedge CLK); t++; end
    @(posedge CLK); #1;
    c_in_valid = 1'b0;
    t = 0;
    @(negedge CLK);
    while (!c_out_valid && t < 20) begin @(negedge CLK); t++; end
    check({tag, "_valid"}, c_out_valid, 1);
    check(tag, c_result, exp_res);
    check({tag, "_nv"}, c_out_nv, exp_nv);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_nv_sticky", nv_sticky, 0);

    // min/max with signed zeros, full throughput, latency checked
    send(F_MINMAX, 3'd0, 16'h0000, 16'h8000);
    send(F_MINMAX, 3'd1, 16'h8000, 16'h0000);
    send(F_MINMAX, 3'd1, 16'h7C01, 16'h3C00);
    send(F_MINMAX, 3'd0, 16'h7E00, 16'h7D00);
    send(F_MINMAX, 3'd0, 16'hC000, 16'h3C00);
    send(F_MINMAX, 3'd1, 16'h7E00, 16'hBC00);
    // comparisons
    send(F_COMP, 3'd2, 16'h7E00, 16'h3C00);
    send(F_COMP, 3'd1, 16'h7E00, 16'h3C00);
    send(F_COMP, 3'd0, 16'hBC00, 16'h3C00);
    send(F_COMP, 3'd2, 16'h8000, 16'h0000);
    send(F_COMP, 3'd1, 16'hC000, 16'hBC00);
    send(F_COMP, 3'd0, 16'h3C01, 16'h3C00);
    send(F_COMP, 3'd2, 16'h7D00, 16'h7D00);
    // classify and sign injection
    send(F_CLASS, 3'd1, 16'h0001, 16'h0000);
    send(F_CLASS, 3'd1, 16'hFC00, 16'h0000);
    send(F_CLASS, 3'd1, 16'h7D00, 16'h0000);
    send(F_CLASS, 3'd1, 16'h8000, 16'h0000);
    send(F_CLASS, 3'd1, 16'h3C00, 16'h0000);
    send(F_CLASS, 3'd1, 16'h7E00, 16'h0000);
    send(F_SGNJ, 3'd2, 16'hBC00, 16'h8000);
    send(F_SGNJ, 3'd0, 16'h3C00, 16'h8000);
    send(F_SGNJ, 3'd1, 16'hBC00, 16'h8000);
    // illegal encodings still flow through
    send(F_SGNJ, 3'd3, 16'h3C00, 16'h8000);
    send(F_CLASS, 3'd0, 16'h3C00, 16'h0000);
    send(F_COMP, 3'd5, 16'h7C01, 16'h3C00);
    send(5'b00000, 3'd0, 16'h3C00, 16'h3C00);
    drain();
    check("sticky_after_nv", nv_sticky, 1);

    // clear, then set and clear together: set wins for one cycle
    nv_clear = 1'b1; @(posedge CLK); #1; nv_clear = 1'b0;
    check("sticky_cleared", nv_sticky, 0);
    nv_clear = 1'b1;
    send(F_COMP, 3'd1, 16'h7E00, 16'h3C00);
    drain();
    nv_clear = 1'b0;

    // backpressure: two accepts fill the pipe, then in_ready drops
    lat_check = 1'b0;
    out_ready = 1'b0;
    base = n_out;
    fork
      begin
        send(F_SGNJ, 3'd1, 16'h4000, 16'h0000);
        send(F_CLASS, 3'd1, 16'h0200, 16'h0000);
        send(F_MINMAX, 3'd1, 16'h4200, 16'h4400);
        send(F_COMP, 3'd0, 16'h4400, 16'h4400);
      end
      begin
        int acc0;
        acc0 = n_acc;
        repeat (6) @(posedge CLK);
        #1;
        check("bp_accepts", n_acc - acc0, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_outputs", n_out - base, 4);

    // reset with two operations in flight
    send(F_MINMAX, 3'd0, 16'h7C01, 16'h3C00);
    drain();
    out_ready = 1'b0;
    send(F_SGNJ, 3'd0, 16'h3C00, 16'h8000);
    send(F_SGNJ, 3'd1, 16'h3C00, 16'h8000);
    check("pre_rst_sticky", nv_sticky, 1);
    #2 nRST = 1'b0;
    #1;
    check("rst_async_out_valid", out_valid, 0);
    check("rst_async_sticky", nv_sticky, 0);
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    out_ready = 1'b1;
    base = n_out;
    repeat (8) @(posedge CLK);
    #1;
    check("rst_no_emit", n_out - base, 0);
    check("rst_in_ready_after", in_ready, 1);

    // single-precision instance
    send32("f32_fmin_zero", F_MINMAX, 3'd0, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0);
    send32("f32_fmax_nan", F_MINMAX, 3'd1, 32'hBF80_0000, 32'h7FC0_0000, 32'hBF80_0000, 1'b0);
    send32("f32_fmin_2nan", F_MINMAX, 3'd0, 32'h7F80_0001, 32'h7FC0_0001, 32'h7FC0_0000, 1'b1);
    send32("f32_fclass", F_CLASS, 3'd1, 32'h8000_0000, 32'h0, 32'h0000_0008, 1'b0);
    send32("f32_flt", F_COMP, 3'd1, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0001, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
